// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter for one shared resource with a one-hot ring priority pointer.
// The pointer rotates past each owner on release. An optional hold limit forces rotation.
module ring_rr_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16,
  localparam int IW      = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx,
  output logic          preempt
);

  // state | meaning
  // IDLE  | no owner, gnt all-zero
  // GRANT | one client owns the resource, gnt one-hot
  typedef enum logic {IDLE, GRANT} state_t;

  localparam int HW         = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam bit HOLD_LIMIT = (MAX_HOLD != 0);

  state_t          state, state_n;
  logic [N-1:0]    ptr, ptr_n;
  logic [N-1:0]    gnt_n;
  logic [HW-1:0]   hold_cnt, hold_n;
  logic            preempt_n;
  logic [N-1:0]    others;
  logic [N-1:0]    ptr_next_owner;

  function automatic logic [N-1:0] rotl1(input logic [N-1:0] v);
    return {v[N-2:0], v[N-1]};
  endfunction

  // First set bit of r, scanning upward from the pointer bit with wrap.
  function automatic logic [N-1:0] rr_pick(input logic [N-1:0] r, input logic [N-1:0] p);
    logic [N-1:0] res;
    logic         found;
    res = '0;
    for (int i = 0; i < N; i++) begin
      if (p[i]) begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          if (!found && r[(i + k) % N]) begin
            res[(i + k) % N] = 1'b1;
            found = 1'b1;
          end
        end
      end
    end
    return res;
  endfunction

  function automatic logic [IW-1:0] onehot_to_idx(input logic [N-1:0] v);
    logic [IW-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) idx = IW'(i);
    end
    return idx;
  endfunction

  assign others         = req & ~gnt;
  assign ptr_next_owner = rotl1(gnt);

  always_comb begin
    state_n   = state;
    gnt_n     = gnt;
    ptr_n     = ptr;
    hold_n    = hold_cnt;
    preempt_n = 1'b0;
    case (state)
      IDLE: begin
        gnt_n = '0;
        if (|req) begin
          gnt_n   = rr_pick(req, ptr);
          hold_n  = HW'(1);
          state_n = GRANT;
        end
      end
      GRANT: begin
        if (!(|(req & gnt))) begin
          // Release: the new pointer also serves the same-edge re-arbitration.
          ptr_n = ptr_next_owner;
          gnt_n = rr_pick(req, ptr_next_owner);
          if (|gnt_n) begin
            hold_n = HW'(1);
          end else begin
            hold_n  = '0;
            state_n = IDLE;
          end
        end else if (HOLD_LIMIT && hold_cnt == HW'(MAX_HOLD)) begin
          hold_n = HW'(1);
          if (|others) begin
            ptr_n     = ptr_next_owner;
            gnt_n     = rr_pick(others, ptr_next_owner);
            preempt_n = 1'b1;
          end
        end else if (HOLD_LIMIT) begin
          hold_n = hold_cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
        hold_n  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= {{(N-1){1'b0}}, 1'b1};
      hold_cnt  <= '0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_idx   <= '0;
      preempt   <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      hold_cnt  <= hold_n;
      gnt       <= gnt_n;
      gnt_valid <= |gnt_n;
      gnt_idx   <= onehot_to_idx(gnt_n);
      preempt   <= preempt_n;
    end
  end

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Bench for ring_rr_arbiter: directed scenarios plus sticky random requests,
// all compared against an index-based round-robin model.
module tb_ring_rr_arbiter;
  localparam int N  = 4;
  localparam int MH = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic         gnt_valid;
  logic [1:0]   gnt_idx;
  logic         preempt;

  int checks = 0;
  int errors = 0;

  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;
  bit m_pre   = 1'b0;
  int wait_cnt [N];

  ring_rr_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .preempt   (preempt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int search(input logic [N-1:0] r, input int p, input int excl);
    int j;
    for (int k = 0; k < N; k++) begin
      j = (p + k) % N;
      if (j != excl && r[j]) return j;
    end
    return -1;
  endfunction

  task automatic model(input logic [N-1:0] r, input bit rst);
    int prev;
    logic [N-1:0] rest;
    prev  = m_owner;
    m_pre = 1'b0;
    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
      m_hold  = 0;
    end else if (m_owner < 0) begin
      m_owner = search(r, m_ptr, -1);
      if (m_owner >= 0) m_hold = 1;
    end else if (!r[m_owner]) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = search(r, m_ptr, -1);
      m_hold  = (m_owner >= 0) ? 1 : 0;
    end else if (m_hold == MH) begin
      rest = r;
      rest[m_owner] = 1'b0;
      m_hold = 1;
      if (rest != '0) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = search(r, m_ptr, m_owner);
        m_pre   = 1'b1;
      end
    end else begin
      m_hold++;
    end
    for (int i = 0; i < N; i++) begin
      if (rst || !r[i] || m_owner == i) begin
        wait_cnt[i] = 0;
      end else if (m_owner >= 0 && m_owner != prev) begin
        wait_cnt[i]++;
        chk("starve", 32'(wait_cnt[i] <= N - 1), 32'd1);
      end
    end
  endtask

  task automatic step(input logic [N-1:0] r, input bit rst);
    logic [N-1:0] eg;
    @(negedge clk);
    req   = r;
    reset = rst;
    @(posedge clk);
    model(r, rst);
    #1;
    eg = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
    chk("gnt_idx", 32'(gnt_idx), (m_owner >= 0) ? m_owner : 0);
    chk("preempt", 32'(preempt), 32'(m_pre));
    chk("onehot", 32'($onehot0(gnt)), 32'd1);
  endtask

  initial begin
    logic [N-1:0] one;
    logic [N-1:0] cur;
    one = 1;
    req = '0;
    reset = 1'b1;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;

    // reset and idle
    step('0, 1'b1);
    step('0, 1'b1);
    for (int i = 0; i < 5; i++) step(4'b0000, 1'b0);
    chk("idle_gnt", 32'(gnt), 32'd0);
    chk("idle_idx", 32'(gnt_idx), 32'd0);

    // rotation with 1-cycle drops, no bubbles
    step(4'b1111, 1'b0);
    for (int k = 0; k < 5; k++) begin
      chk("rotate_gnt", 32'(gnt), 32'(one << (k % N)));
      chk("rotate_valid", 32'(gnt_valid), 32'd1);
      step(4'b1111, 1'b0);
      step(4'b1111, 1'b0);
      step(4'b1111 & ~(one << (k % N)), 1'b0);
    end

    // hold-limit preemption between two requesters
    step('0, 1'b1);
    step(4'b0011, 1'b0);
    chk("hold0_start", 32'(gnt), 32'b0001);
    for (int i = 0; i < MH - 1; i++) step(4'b0011, 1'b0);
    chk("hold0_end", 32'(gnt), 32'b0001);
    step(4'b0011, 1'b0);
    chk("preempt_gnt", 32'(gnt), 32'b0010);
    chk("preempt_pulse", 32'(preempt), 32'd1);
    step(4'b0011, 1'b0);
    chk("preempt_drop", 32'(preempt), 32'd0);
    for (int i = 0; i < MH - 2; i++) step(4'b0011, 1'b0);
    chk("hold1_end", 32'(gnt), 32'b0010);
    step(4'b0011, 1'b0);
    chk("back_to_0", 32'(gnt), 32'b0001);

    // lone requester is never preempted
    step('0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      step(4'b0100, 1'b0);
      chk("lone_gnt", 32'(gnt), 32'b0100);
      chk("lone_preempt", 32'(preempt), 32'd0);
    end

    // wrap-around on owner 3 release
    step('0, 1'b1);
    step(4'b1000, 1'b0);
    chk("own3", 32'(gnt), 32'b1000);
    step(4'b0101, 1'b0);
    chk("wrap", 32'(gnt), 32'b0001);

    // reset mid-grant restores pointer to client 0
    step('0, 1'b1);
    step(4'b0001, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0100, 1'b0);
    chk("mid_gnt", 32'(gnt), 32'b0100);
    step(4'b0100, 1'b1);
    chk("mid_reset", 32'(gnt), 32'd0);
    step(4'b0000, 1'b0);
    step(4'b1100, 1'b0);
    chk("post_reset", 32'(gnt), 32'b0100);

    // sticky random requests
    cur = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(11) == 0) cur[i] = ~cur[i];
      end
      step(cur, ($urandom_range(399) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
